// File: rtl/output_argmax.sv
// Argmax stage behind the output-layer neurons: streams one frame of signed scores,
// tracks the running maximum and hands the winning index and score to the consumer.
//
// state | meaning
// IDLE  | waiting for the first score of a frame
// ACCUM | mid-frame, comparing each beat against the running maximum
// HOLD  | result presented, waiting for the consumer to take it
module output_argmax #(
  parameter int DATA_W      = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              score_valid,
  output logic              score_ready,
  input  logic [DATA_W-1:0] score_data,
  input  logic              score_last,
  output logic              class_valid,
  input  logic              class_ready,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] class_score,
  output logic              frame_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t            state;
  logic [IDX_W-1:0]  count;
  logic [IDX_W-1:0]  max_idx;
  logic [DATA_W-1:0] max_score;

  logic              beat;
  logic [IDX_W-1:0]  beat_idx;
  logic [IDX_W-1:0]  cand_idx;
  logic [DATA_W-1:0] cand_score;
  logic              final_beat;
  logic              end_frame;
  logic              bad_frame;

  always_comb begin
    score_ready = !reset && (state != HOLD);
    beat        = score_valid && score_ready;
    beat_idx    = (state == ACCUM) ? count : '0;
    // First beat of a frame always loads; later beats need a strictly greater
    // score so that ties stay with the lower index.
    if (state != ACCUM || $signed(score_data) > $signed(max_score)) begin
      cand_score = score_data;
      cand_idx   = beat_idx;
    end else begin
      cand_score = max_score;
      cand_idx   = max_idx;
    end
    final_beat = (beat_idx == LAST_IDX);
    end_frame  = score_last || final_beat;
    bad_frame  = score_last ^ final_beat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      max_idx     <= '0;
      max_score   <= '0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      frame_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat) begin
            if (end_frame) begin
              class_idx   <= cand_idx;
              class_score <= cand_score;
              frame_err   <= bad_frame;
              class_valid <= 1'b1;
              count       <= '0;
              state       <= HOLD;
            end else begin
              max_idx   <= cand_idx;
              max_score <= cand_score;
              count     <= beat_idx + 1'b1;
              state     <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (class_ready) begin
            class_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          count       <= '0;
          class_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax: hand-computed frames, boundary cases,
// back-pressure in HOLD and reset mid-frame.
module tb_output_argmax;

  logic        clk = 1'b0;
  logic        reset;
  logic        score_valid;
  logic        score_ready;
  logic [15:0] score_data;
  logic        score_last;
  logic        class_valid;
  logic        class_ready;
  logic [3:0]  class_idx;
  logic [15:0] class_score;
  logic        frame_err;

  int total = 0;
  int bad   = 0;
  int fr [10];

  output_argmax dut (
    .clk         (clk),
    .reset       (reset),
    .score_valid (score_valid),
    .score_ready (score_ready),
    .score_data  (score_data),
    .score_last  (score_last),
    .class_valid (class_valid),
    .class_ready (class_ready),
    .class_idx   (class_idx),
    .class_score (class_score),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat; waits a bounded time for score_ready.
  task automatic beat(input int d, input logic l);
    int waited = 0;
    while (!score_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("beat_ready", 32'(score_ready), 32'd1);
    score_valid = 1'b1;
    score_data  = 16'(d);
    score_last  = l;
    tick();
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  // Sends fr[0..n-1]; last_at < 0 means no score_last in the frame.
  task automatic send_frame(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      beat(fr[i], (i == last_at));
      if (i != n - 1) chk("no_early_valid", 32'(class_valid), 32'd0);
    end
  endtask

  task automatic take_result(input int e_idx, input logic [15:0] e_score, input logic e_err);
    chk("class_valid", 32'(class_valid), 32'd1);
    chk("class_idx", 32'(class_idx), 32'(e_idx));
    chk("class_score", 32'(class_score), 32'(e_score));
    chk("frame_err", 32'(frame_err), 32'(e_err));
    chk("hold_not_ready", 32'(score_ready), 32'd0);
    class_ready = 1'b1;
    tick();
    class_ready = 1'b0;
    chk("valid_dropped", 32'(class_valid), 32'd0);
    chk("ready_back", 32'(score_ready), 32'd1);
    chk("idx_retained", 32'(class_idx), 32'(e_idx));
  endtask

  initial begin
    reset       = 1'b1;
    score_valid = 1'b0;
    score_data  = '0;
    score_last  = 1'b0;
    class_ready = 1'b0;
    tick(); tick(); tick();
    chk("rst_ready", 32'(score_ready), 32'd0);
    chk("rst_valid", 32'(class_valid), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    chk("rst_score", 32'(class_score), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(score_ready), 32'd1);

    fr = '{10, 20, 5, 0, -3, 99, 40, 98, 1, 2};
    send_frame(10, 9);
    take_result(5, 16'd99, 1'b0);

    fr = '{0, 0, 256, 0, 0, 0, 256, 0, 0, 0};
    send_frame(10, 9);
    take_result(2, 16'h0100, 1'b0);

    fr = '{-5, -6, -7, -8, -9, -10, -11, -12, -13, 32768};
    send_frame(10, 9);
    take_result(0, 16'hFFFB, 1'b0);

    fr = '{1, 2, 3, 7, -1, 4, 0, 0, 0, 0};
    send_frame(6, 5);
    take_result(3, 16'd7, 1'b1);

    // No score_last: frame closes on the tenth beat and is flagged.
    fr = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    send_frame(10, -1);
    take_result(5, 16'd9, 1'b1);

    // Back-pressure: result must hold while a pending score is refused.
    fr = '{-1, -2, -3, -4, 50, -6, -7, -8, -9, 50};
    send_frame(10, 9);
    score_valid = 1'b1;
    score_data  = 16'd1000;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready", 32'(score_ready), 32'd0);
      chk("bp_valid", 32'(class_valid), 32'd1);
      chk("bp_idx", 32'(class_idx), 32'd4);
      chk("bp_score", 32'(class_score), 32'd50);
      tick();
    end
    score_valid = 1'b0;
    take_result(4, 16'd50, 1'b0);

    fr = '{7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    send_frame(10, 9);
    take_result(9, 16'd16, 1'b0);

    // Reset after four beats drops the partial frame and clears outputs.
    fr = '{100, 200, 300, 400, 0, 0, 0, 0, 0, 0};
    send_frame(4, -1);
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(score_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(class_valid), 32'd0);
    chk("mid_rst_idx", 32'(class_idx), 32'd0);
    chk("mid_rst_score", 32'(class_score), 32'd0);
    chk("mid_rst_err", 32'(frame_err), 32'd0);

    fr = '{-20, -30, 5, -40, 4, 3, 6, 2, 1, 0};
    send_frame(10, 9);
    take_result(6, 16'd6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
